// File: rtl/poly_pkg.sv
// Shared types and constants for the Horner polynomial datapath.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package poly_pkg;

    localparam int NUM_COEF = 4;
    localparam int DW_DEF   = 16;
    localparam int FRAC_DEF = 8;

    // Coefficient index, also used as the Horner-step coefficient select
    typedef logic [1:0] coef_idx_t;

    // Most positive (neg=0) or most negative (neg=1) value of a w-bit signed number
    function automatic logic signed [63:0] sat_limit(input int w, input logic neg);
        logic signed [63:0] one;
        one = 64'sd1;
        return neg ? -(one <<< (w - 1)) : (one <<< (w - 1)) - one;
    endfunction

endpackage

// File: rtl/poly_datapath_if.sv
// Strobe, coefficient-write and result handshake bundle of the polynomial datapath.
// Latency: n/a (wires only).
// Backpressure: y_valid/y_ready on the result; all other signals are unthrottled strobes.
interface poly_datapath_if #(parameter int DW = poly_pkg::DW_DEF);
    import poly_pkg::*;

    logic          x_ld;
    logic          sum_ld;
    logic          sum_clr;
    coef_idx_t     mult_sel;
    logic          y_ld;
    logic [DW-1:0] x_in;
    logic          coef_we;
    coef_idx_t     coef_addr;
    logic [DW-1:0] coef_wdata;
    logic [DW-1:0] y_out;
    logic          y_valid;
    logic          y_ready;
    logic          ovf;
    logic          overrun;
    logic          flag_clr;

    // Controller / consumer side
    modport master (
        output x_ld, sum_ld, sum_clr, mult_sel, y_ld, x_in,
               coef_we, coef_addr, coef_wdata, y_ready, flag_clr,
        input  y_out, y_valid, ovf, overrun
    );

    // Datapath side
    modport slave (
        input  x_ld, sum_ld, sum_clr, mult_sel, y_ld, x_in,
               coef_we, coef_addr, coef_wdata, y_ready, flag_clr,
        output y_out, y_valid, ovf, overrun
    );

endinterface

// File: rtl/poly_mac_step.sv
// One Horner step: acc*x (fixed point, floor-shifted by FRAC) + coef, reduced to DW bits.
// Latency: combinational. Saturating clamp only when POLY_DATAPATH_SAT_EN is defined, else wrap.
// Backpressure: none; overflow is always reported regardless of build.
module poly_mac_step
    import poly_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] xop,
    input  logic [DW-1:0] coef,
    output logic [DW-1:0] acc_nxt,
    output logic          ovf
);

    localparam int PW = 2 * DW;

    logic signed [PW-1:0] acc_x;
    logic signed [PW-1:0] xop_x;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_sh;
    logic signed [PW:0]   sum;
    logic [PW-DW+1:0]     sum_hi;

    // Full-precision product, rescale, add coefficient, detect and reduce
    always_comb begin
        acc_x   = {{DW{acc[DW-1]}}, acc};
        xop_x   = {{DW{xop[DW-1]}}, xop};
        prod    = acc_x * xop_x;
        prod_sh = prod >>> FRAC;
        sum     = {prod_sh[PW-1], prod_sh} + {{(DW + 1){coef[DW-1]}}, coef};
        // In range only if every bit above the result's sign bit matches it
        sum_hi  = sum[PW:DW-1];
        ovf     = !((&sum_hi) || !(|sum_hi));
`ifdef POLY_DATAPATH_SAT_EN
        if (ovf) begin
            acc_nxt = sum[PW] ? DW'(sat_limit(DW, 1'b1)) : DW'(sat_limit(DW, 1'b0));
        end else begin
            acc_nxt = sum[DW-1:0];
        end
`else
        acc_nxt = sum[DW-1:0];
`endif
    end

endmodule

// File: rtl/poly_datapath.sv
// Horner polynomial datapath: x register, 4-entry coefficient bank, accumulator, result register.
// Latency: 1 cycle per Horner step; result registered on y_ld. Optional clamp: POLY_DATAPATH_SAT_EN.
// Backpressure: y_valid/y_ready; a y_ld onto an unaccepted result overwrites it and sets overrun.
module poly_datapath
    import poly_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    poly_datapath_if.slave   bus
);

    logic [DW-1:0] x_reg;
    logic [DW-1:0] coef_reg [NUM_COEF];
    logic [DW-1:0] acc_reg;
    logic [DW-1:0] y_reg;
    logic          y_valid_reg;
    logic          ovf_reg;
    logic          overrun_reg;

    logic [DW-1:0] xop;
    logic [DW-1:0] step_acc;
    logic          step_ovf;
    logic          ovf_evt;
    logic          overrun_evt;

    // First step of a sequence loads x and steps together, so bypass the register
    assign xop = bus.x_ld ? bus.x_in : x_reg;

    poly_mac_step #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_step (
        .acc     (acc_reg),
        .xop     (xop),
        .coef    (coef_reg[bus.mult_sel]),
        .acc_nxt (step_acc),
        .ovf     (step_ovf)
    );

    // A clear overrides the step, so its arithmetic cannot raise ovf
    assign ovf_evt     = bus.sum_ld && !bus.sum_clr && step_ovf;
    assign overrun_evt = bus.y_ld && y_valid_reg && !bus.y_ready;

    // Operand and coefficient storage; a same-cycle write and step read sees the old coefficient
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg <= '0;
            for (int i = 0; i < NUM_COEF; i++) begin
                coef_reg[i] <= '0;
            end
        end else begin
            if (bus.x_ld) begin
                x_reg <= bus.x_in;
            end
            if (bus.coef_we) begin
                coef_reg[bus.coef_addr] <= bus.coef_wdata;
            end
        end
    end

    // Accumulator: clear beats step beats hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (bus.sum_clr) begin
            acc_reg <= '0;
        end else if (bus.sum_ld) begin
            acc_reg <= step_acc;
        end
    end

    // Result register and valid; a new load wins over a completing transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
        end else if (bus.y_ld) begin
            y_reg       <= acc_reg;
            y_valid_reg <= 1'b1;
        end else if (y_valid_reg && bus.y_ready) begin
            y_valid_reg <= 1'b0;
        end
    end

    // Sticky flags; a setting event in the clear cycle keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            ovf_reg     <= (ovf_reg && !bus.flag_clr) || ovf_evt;
            overrun_reg <= (overrun_reg && !bus.flag_clr) || overrun_evt;
        end
    end

    assign bus.y_out   = y_reg;
    assign bus.y_valid = y_valid_reg;
    assign bus.ovf     = ovf_reg;
    assign bus.overrun = overrun_reg;

endmodule

// File: tb/tb_poly_datapath.sv
// Self-checking bench for poly_datapath: directed plan sequences plus randomized strobes.
// Latency: reference model advances once per clock and is compared every cycle on the falling edge.
// Backpressure: y_ready driven by the bench (held low, pulsed, or random).
module tb_poly_datapath;
    import poly_pkg::*;

    localparam int DW   = 16;
    localparam int FRAC = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    poly_datapath_if #(.DW(DW)) bus();

    poly_datapath #(.DW(DW), .FRAC(FRAC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state in plain signed integers (real-valued * 2^FRAC)
    longint m_x;
    longint m_acc;
    longint m_coef [NUM_COEF];
    longint m_y;
    bit     m_vld;
    bit     m_ovf;
    bit     m_ovr;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [31:0] lo(input longint v);
        logic [63:0] u;
        u = v;
        return 32'(u[DW-1:0]);
    endfunction

    // Polynomial step with plain integer arithmetic: floor(acc*x / 2^FRAC) + c
    function automatic longint mstep(input longint acc, input longint x, input longint c,
                                     output bit o);
        longint one;
        longint hi;
        longint lw;
        longint s;
        longint w;
        one = 1;
        hi  = (one <<< (DW - 1)) - 1;
        lw  = -(one <<< (DW - 1));
        s   = ((acc * x) >>> FRAC) + c;
        o   = (s > hi) || (s < lw);
`ifdef POLY_DATAPATH_SAT_EN
        w = s;
        if (s > hi) w = hi;
        if (s < lw) w = lw;
`else
        w = s & ((one <<< DW) - 1);
        if (w > hi) w = w - (one <<< DW);
`endif
        return w;
    endfunction

    task automatic model_reset();
        m_x = 0; m_acc = 0; m_y = 0;
        m_vld = 0; m_ovf = 0; m_ovr = 0;
        for (int i = 0; i < NUM_COEF; i++) m_coef[i] = 0;
    endtask

    task automatic idle();
        bus.x_ld = 0; bus.sum_ld = 0; bus.sum_clr = 0; bus.mult_sel = 0;
        bus.y_ld = 0; bus.x_in = 0; bus.coef_we = 0; bus.coef_addr = 0;
        bus.coef_wdata = 0; bus.y_ready = 0; bus.flag_clr = 0;
    endtask

    // One clock: compute the model's next state from the applied inputs, clock, compare
    task automatic tick();
        longint n_acc;
        longint n_x;
        longint n_y;
        bit     n_vld;
        bit     step_o;
        bit     ovr_e;
        longint xop;
        n_acc  = m_acc;
        n_x    = m_x;
        n_y    = m_y;
        n_vld  = m_vld;
        step_o = 0;
        ovr_e  = 0;
        if (bus.sum_clr) begin
            n_acc = 0;
        end else if (bus.sum_ld) begin
            xop   = bus.x_ld ? sx(bus.x_in) : m_x;
            n_acc = mstep(m_acc, xop, m_coef[bus.mult_sel], step_o);
        end
        if (bus.x_ld) n_x = sx(bus.x_in);
        if (bus.y_ld) begin
            ovr_e = m_vld && !bus.y_ready;
            n_y   = m_acc;
            n_vld = 1;
        end else if (m_vld && bus.y_ready) begin
            n_vld = 0;
        end
        @(posedge clk);
        if (bus.coef_we) m_coef[bus.coef_addr] = sx(bus.coef_wdata);
        m_ovf = (m_ovf && !bus.flag_clr) || step_o;
        m_ovr = (m_ovr && !bus.flag_clr) || ovr_e;
        m_acc = n_acc;
        m_x   = n_x;
        m_y   = n_y;
        m_vld = n_vld;
        @(negedge clk);
        check_val("y_out",   32'(bus.y_out),   lo(m_y));
        check_val("y_valid", 32'(bus.y_valid), 32'(m_vld));
        check_val("ovf",     32'(bus.ovf),     32'(m_ovf));
        check_val("overrun", 32'(bus.overrun), 32'(m_ovr));
    endtask

    task automatic set_coefs(input logic [15:0] c0, input logic [15:0] c1,
                             input logic [15:0] c2, input logic [15:0] c3);
        logic [15:0] cv [NUM_COEF];
        cv[0] = c0; cv[1] = c1; cv[2] = c2; cv[3] = c3;
        for (int i = 0; i < NUM_COEF; i++) begin
            idle();
            bus.coef_we = 1; bus.coef_addr = 2'(i); bus.coef_wdata = cv[i];
            tick();
        end
        idle();
    endtask

    // Controller sequence: clr; x_ld+sum_ld sel3; sel0; sel2; sel1; y_ld
    task automatic run_seq(input logic [15:0] x, input bit wr3, input logic [15:0] wd);
        idle(); bus.sum_clr = 1; tick();
        idle(); bus.x_ld = 1; bus.x_in = x; bus.sum_ld = 1; bus.mult_sel = 2'd3;
        bus.coef_we = wr3; bus.coef_addr = 2'd3; bus.coef_wdata = wd; tick();
        idle(); bus.sum_ld = 1; bus.mult_sel = 2'd0; tick();
        idle(); bus.sum_ld = 1; bus.mult_sel = 2'd2; tick();
        idle(); bus.sum_ld = 1; bus.mult_sel = 2'd1; tick();
        idle(); bus.y_ld = 1; tick();
        idle();
    endtask

    task automatic consume();
        idle(); bus.y_ready = 1; tick(); idle();
    endtask

    initial begin
        int v;
        idle();
        model_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        check_val("rst_y_out",   32'(bus.y_out),   32'h0);
        check_val("rst_y_valid", 32'(bus.y_valid), 32'h0);
        check_val("rst_ovf",     32'(bus.ovf),     32'h0);
        check_val("rst_overrun", 32'(bus.overrun), 32'h0);
        reset = 0;

        // Cube
        set_coefs(16'h0000, 16'h0000, 16'h0000, 16'h0100);
        run_seq(16'h0200, 0, 16'h0);
        check_val("cube_y", 32'(bus.y_out), 32'h0800);
        check_val("cube_vld", 32'(bus.y_valid), 32'h1);
        check_val("cube_ovf", 32'(bus.ovf), 32'h0);
        consume();

        // All-ones polynomial at 2.0 and -1.0, then x^3 at -1.0
        set_coefs(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        run_seq(16'h0200, 0, 16'h0);
        check_val("ones_x2", 32'(bus.y_out), 32'h0F00);
        consume();
        run_seq(16'hFF00, 0, 16'h0);
        check_val("ones_xm1", 32'(bus.y_out), 32'h0000);
        consume();
        set_coefs(16'h0000, 16'h0000, 16'h0000, 16'h0100);
        run_seq(16'hFF00, 0, 16'h0);
        check_val("cube_xm1", 32'(bus.y_out), 32'hFF00);
        consume();

        // Saturation / wrap
        run_seq(16'h7F00, 0, 16'h0);
`ifdef POLY_DATAPATH_SAT_EN
        check_val("sat_y", 32'(bus.y_out), 32'h7FFF);
`else
        check_val("wrap_y", 32'(bus.y_out), 32'h7F00);
`endif
        check_val("sat_ovf", 32'(bus.ovf), 32'h1);
        consume();
        bus.flag_clr = 1; tick(); idle();
        check_val("ovf_clr", 32'(bus.ovf), 32'h0);

        // Coefficient write in the same cycle as its read uses the old value
        set_coefs(16'h0000, 16'h0000, 16'h0000, 16'h0100);
        run_seq(16'h0200, 1, 16'h0200);
        check_val("haz_old_coef", 32'(bus.y_out), 32'h0800);
        consume();
        run_seq(16'h0200, 0, 16'h0);
        check_val("haz_new_coef", 32'(bus.y_out), 32'h1000);
        consume();

        // Handshake and overrun
        bus.y_ld = 1; tick(); idle();
        check_val("hs_first", 32'(bus.y_out), 32'h1000);
        bus.sum_clr = 1; tick(); idle();
        bus.y_ld = 1; tick(); idle();
        check_val("hs_second", 32'(bus.y_out), 32'h0000);
        check_val("hs_overrun", 32'(bus.overrun), 32'h1);
        bus.flag_clr = 1; tick(); idle();
        check_val("hs_ovr_clr", 32'(bus.overrun), 32'h0);
        bus.y_ld = 1; bus.y_ready = 1; tick(); idle();
        check_val("hs_ld_rdy_ovr", 32'(bus.overrun), 32'h0);
        check_val("hs_ld_rdy_vld", 32'(bus.y_valid), 32'h1);
        bus.y_ready = 1; tick(); idle();
        check_val("hs_drain", 32'(bus.y_valid), 32'h0);

        // Clear and step together
        set_coefs(16'h0000, 16'h0000, 16'h0000, 16'h0100);
        bus.sum_clr = 1; tick(); idle();
        bus.x_ld = 1; bus.x_in = 16'h0200; bus.sum_ld = 1; bus.mult_sel = 2'd3; tick(); idle();
        bus.sum_clr = 1; bus.sum_ld = 1; bus.mult_sel = 2'd3; tick(); idle();
        bus.y_ld = 1; tick(); idle();
        check_val("clr_and_ld", 32'(bus.y_out), 32'h0000);
        consume();

        // Asynchronous reset mid-sequence with a pending result and ovf set
        run_seq(16'h7F00, 0, 16'h0);
        bus.sum_clr = 1; tick(); idle();
        bus.x_ld = 1; bus.x_in = 16'h0300; bus.sum_ld = 1; bus.mult_sel = 2'd3; tick(); idle();
        #2 reset = 1;
        #1;
        check_val("arst_y_out",   32'(bus.y_out),   32'h0);
        check_val("arst_y_valid", 32'(bus.y_valid), 32'h0);
        check_val("arst_ovf",     32'(bus.ovf),     32'h0);
        check_val("arst_overrun", 32'(bus.overrun), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            idle(); bus.sum_ld = 1; bus.mult_sel = 2'(i); bus.y_ready = 1; tick();
        end
        idle();
        check_val("arst_no_vld", 32'(bus.y_valid), 32'h0);
        run_seq(16'h0200, 0, 16'h0);
        check_val("arst_coef_zero", 32'(bus.y_out), 32'h0000);
        consume();

        // Randomized strobes against the model
        for (int n = 0; n < 600; n++) begin
            bus.x_ld     = ($urandom_range(0, 3) == 0);
            bus.sum_ld   = ($urandom_range(0, 1) == 1);
            bus.sum_clr  = ($urandom_range(0, 7) == 0);
            bus.mult_sel = 2'($urandom_range(0, 3));
            bus.y_ld     = ($urandom_range(0, 5) == 0);
            bus.y_ready  = ($urandom_range(0, 1) == 1);
            bus.coef_we  = ($urandom_range(0, 3) == 0);
            bus.coef_addr = 2'($urandom_range(0, 3));
            bus.flag_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.x_in = 16'($urandom);
            end else begin
                v = int'($urandom_range(0, 1023)) - 512;
                bus.x_in = 16'(v);
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.coef_wdata = 16'($urandom);
            end else begin
                v = int'($urandom_range(0, 1023)) - 512;
                bus.coef_wdata = 16'(v);
            end
            tick();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
